seed_lfsr_gen: RTL and testbench

//  Upstream seed source for the 16-bit seed accumulator: produces a stream of pseudo-random

---
 rtl/seed_lfsr_gen_if.sv | 22 ++
 rtl/seed_lfsr_gen.sv | 90 +++++++++
 tb/tb_seed_lfsr_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/seed_lfsr_gen_if.sv
// Output stream bundle for seed_lfsr_gen: one word per accepted valid/ready handshake.
// A word transfers on any rising edge where nseed_valid and nseed_ready are both high;
// while valid is high and ready low, nseed stays stable and valid stays asserted.
interface seed_lfsr_gen_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] nseed;
    logic             nseed_valid;
    logic             nseed_ready;

    modport master (
        output nseed,
        output nseed_valid,
        input  nseed_ready
    );

    modport slave (
        input  nseed,
        input  nseed_valid,
        output nseed_ready
    );
endinterface

// File: rtl/seed_lfsr_gen.sv
// Galois-LFSR seed source emitting programmable-length bursts over a valid/ready stream.
// The LFSR state carries over between bursts, so successive bursts continue one sequence.
module seed_lfsr_gen #(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1,
    parameter int               CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    seed_lfsr_gen_if.master  nseed_if,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lfsr_q, lfsr_d;
    logic [CNT_W:0]   remaining_q, remaining_d;
    logic             handshake;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur);
        lfsr_step = cur[0] ? ((cur >> 1) ^ TAPS) : (cur >> 1);
    endfunction

    // Outputs decode only registered state, so nothing combinational reaches them from inputs.
    assign nseed_if.nseed       = lfsr_q;
    assign nseed_if.nseed_valid = (state_q == RUN);
    assign busy                 = (state_q == RUN);
    assign done                 = (state_q == DONE);
    assign dbg_state            = state_q;

    assign handshake = (state_q == RUN) && nseed_if.nseed_ready;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (seed_we) begin
                    lfsr_d = (seed_in == '0) ? DEFAULT_SEED : seed_in;
                end
                if (start) begin
                    // count==0 encodes a full 2**CNT_W-word burst.
                    remaining_d = (count == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, count};
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    lfsr_d      = lfsr_step(lfsr_q);
                    remaining_d = remaining_q - {{CNT_W{1'b0}}, 1'b1};
                    if (remaining_q == {{CNT_W{1'b0}}, 1'b1}) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= DEFAULT_SEED;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            remaining_q <= remaining_d;
        end
    end

endmodule

// File: tb/tb_seed_lfsr_gen.sv
// Directed bench for seed_lfsr_gen: per-cycle vector table plus a full-length burst sequence.
module tb_seed_lfsr_gen;

    localparam int WIDTH = 16;
    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             seed_we;
    logic [WIDTH-1:0] seed_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    int n_cmp;
    int n_mis;

    seed_lfsr_gen_if #(.WIDTH(WIDTH)) sif ();

    seed_lfsr_gen #(
        .WIDTH       (WIDTH),
        .TAPS        (16'hB400),
        .DEFAULT_SEED(16'hACE1),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .seed_we  (seed_we),
        .seed_in  (seed_in),
        .start    (start),
        .count    (count),
        .nseed_if (sif.master),
        .busy     (busy),
        .done     (done),
        .dbg_state(dbg_state)
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             rst;
        logic             seed_we;
        logic [WIDTH-1:0] seed_in;
        logic             start;
        logic [CNT_W-1:0] count;
        logic             ready;
        logic [WIDTH-1:0] e_nseed;
        logic             e_valid;
        logic             e_busy;
        logic             e_done;
    } vec_t;

    vec_t             vecs[$];
    logic [WIDTH-1:0] exp_q[$];

    function automatic logic [WIDTH-1:0] ref_step(input logic [WIDTH-1:0] cur);
        ref_step = cur[0] ? ((cur >> 1) ^ 16'hB400) : (cur >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic r, input logic we, input logic [WIDTH-1:0] si,
                           input logic st, input logic [CNT_W-1:0] cnt, input logic rdy,
                           input logic [WIDTH-1:0] en, input logic ev, input logic eb,
                           input logic ed);
        vec_t v;
        v.rst = r; v.seed_we = we; v.seed_in = si; v.start = st; v.count = cnt;
        v.ready = rdy; v.e_nseed = en; v.e_valid = ev; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    // Driver: apply one cycle of inputs, clock it, settle past the edge.
    task automatic drive_cycle(input logic r, input logic we, input logic [WIDTH-1:0] si,
                               input logic st, input logic [CNT_W-1:0] cnt, input logic rdy);
        rst = r; seed_we = we; seed_in = si; start = st; count = cnt;
        sif.nseed_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        rst = 1'b1; seed_we = 1'b0; seed_in = '0; start = 1'b0; count = '0;
        sif.nseed_ready = 1'b0;

        //       rst we  seed_in  st cnt  rdy   nseed     v  b  d
        // burst of 3 from reset
        add_vec(1, 0, 16'h0000, 0, 8'd0, 0, 16'hACE1, 0, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 8'd3, 1, 16'hACE1, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'hE270, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h7138, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h389C, 0, 0, 1);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h389C, 0, 0, 0);
        // single-word burst continues the sequence
        add_vec(0, 0, 16'h0000, 1, 8'd1, 1, 16'h389C, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h1C4E, 0, 0, 1);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h1C4E, 0, 0, 0);
        // stall: word held while ready low, seed_we/start ignored in RUN
        add_vec(1, 0, 16'h0000, 0, 8'd0, 0, 16'hACE1, 0, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 8'd2, 0, 16'hACE1, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 0, 16'hACE1, 1, 1, 0);
        add_vec(0, 1, 16'h1234, 1, 8'd7, 0, 16'hACE1, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 0, 16'hACE1, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 0, 16'hACE1, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'hE270, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h7138, 0, 0, 1);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h7138, 0, 0, 0);
        // zero seed remaps; seed_we+start loads and starts together
        add_vec(0, 1, 16'h0000, 0, 8'd0, 0, 16'hACE1, 0, 0, 0);
        add_vec(0, 1, 16'h0001, 1, 8'd2, 0, 16'h0001, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'hB400, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h5A00, 0, 0, 1);
        // start/seed_we during the DONE cycle are ignored
        add_vec(0, 1, 16'hFFFF, 1, 8'd1, 1, 16'h5A00, 0, 0, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h5A00, 0, 0, 0);
        // reset mid-burst after 2 words aborts without done
        add_vec(1, 0, 16'h0000, 0, 8'd0, 1, 16'hACE1, 0, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 8'd5, 1, 16'hACE1, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'hE270, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'h7138, 1, 1, 0);
        add_vec(1, 0, 16'h0000, 0, 8'd0, 1, 16'hACE1, 0, 0, 0);
        add_vec(0, 0, 16'h0000, 1, 8'd1, 1, 16'hACE1, 1, 1, 0);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'hE270, 0, 0, 1);
        add_vec(0, 0, 16'h0000, 0, 8'd0, 1, 16'hE270, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].rst, vecs[i].seed_we, vecs[i].seed_in, vecs[i].start,
                        vecs[i].count, vecs[i].ready);
            check($sformatf("v%0d nseed", i), 32'(sif.nseed), 32'(vecs[i].e_nseed));
            check($sformatf("v%0d valid", i), 32'(sif.nseed_valid), 32'(vecs[i].e_valid));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
            if (i == 0) check("reset state", 32'(dbg_state), 32'd0);
        end

        // Full-length burst (count=0) with periodic stalls and stray start/seed_we pulses.
        begin
            logic [WIDTH-1:0] w;
            logic [WIDTH-1:0] held;
            logic             hs;
            logic             was_valid;
            int               n_hs;
            bit               saw_done;
            w = 16'hE270;
            for (int k = 0; k < 256; k++) begin
                exp_q.push_back(w);
                w = ref_step(w);
            end
            drive_cycle(0, 0, 16'h0000, 1, 8'd0, 1);
            check("full start valid", 32'(sif.nseed_valid), 32'd1);
            check("full start nseed", 32'(sif.nseed), 32'hE270);
            n_hs = 0;
            saw_done = 1'b0;
            for (int c = 0; c < 600 && !saw_done; c++) begin
                sif.nseed_ready = ((c % 7) != 3);
                start   = ((c % 41) == 20);
                seed_we = ((c % 53) == 10);
                seed_in = 16'h5555;
                count   = 8'd3;
                #1;
                was_valid = sif.nseed_valid;
                hs = sif.nseed_valid && sif.nseed_ready;
                held = sif.nseed;
                if (hs) begin
                    if (exp_q.size() == 0) begin
                        check("full extra handshake", 32'(n_hs), 32'd256);
                    end else begin
                        check($sformatf("full word %0d", n_hs), 32'(sif.nseed),
                              32'(exp_q.pop_front()));
                    end
                end
                @(posedge clk);
                #1;
                if (hs) n_hs++;
                else if (was_valid) check($sformatf("full stall c%0d", c), 32'(sif.nseed),
                                          32'(held));
                if (done) saw_done = 1'b1;
            end
            start = 1'b0; seed_we = 1'b0;
            check("full done seen", 32'(saw_done), 32'd1);
            check("full handshake count", 32'(n_hs), 32'd256);
            check("full queue drained", 32'(exp_q.size()), 32'd0);
            drive_cycle(0, 0, 16'h0000, 0, 8'd0, 1);
            check("full back to idle busy", 32'(busy), 32'd0);
            check("full back to idle done", 32'(done), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
